serdes_frame_rx: RTL and testbench
==================================

Name: serdes_frame_rx

Overview:
- Receive-side stage directly downstream of the serializer's `ser_out`.
- Recovers asynchronous-style frames from the serial bitstream: start bit, `DATA_W` data bits LSB-first, optional even-parity bit, stop bit.
- Checks each frame and buffers good words in a small FIFO with a valid/ready output handshake.
- Reports parity, framing and overflow errors to the parallel side.

Parameters:
- DATA_W, 8, data bits per frame.
- PARITY_EN, 1, 1 = even-parity bit present after the data bits; 0 = no parity bit.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ser_in  input  1  serial line; idle level 1.
- bit_en  input  1  bit strobe; `ser_in` is sampled only on cycles where `bit_en`=1.
- clr_err  input  1  synchronous clear of `overflow` and `err_count`.
- out_data  output  DATA_W  FIFO head word; valid only while `out_valid`=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head word when `out_valid` and `out_ready` are both 1.
- parity_err  output  1  one-cycle pulse when a frame fails the parity check.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overflow  output  1  sticky; a good word was dropped because the FIFO was full.
- err_count  output  ERR_CNT_W  saturating count of parity, frame and overflow events.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, shift register=0, bit counter=0, FIFO empty (pointers 0).
- Output reset values: `out_valid`=0, `out_data`=0, `parity_err`=0, `frame_err`=0, `overflow`=0, `err_count`=0, `busy`=0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- FSM advances only on `bit_en`=1 cycles; every other cycle it holds state.
  - IDLE: `ser_in`=0 -> DATA, bit counter=0. `ser_in`=1 -> stay.
  - DATA: shift `ser_in` into the MSB, shift right. After `DATA_W` samples, go to PARITY if `PARITY_EN`=1, otherwise STOP.
  - PARITY: record `perr` = XOR of data bits and the parity bit; 1 means error. Go to STOP.
  - STOP, `ser_in`=1, `perr`=0: push the word, go to IDLE.
  - STOP, `ser_in`=1, `perr`=1: pulse `parity_err`, drop the word, go to IDLE.
  - STOP, `ser_in`=0: pulse `frame_err`, drop the word (no `parity_err` pulse even if `perr`=1), go to BREAK.
  - BREAK: wait for a sampled `ser_in`=1, then go to IDLE. This prevents a stuck-low line from generating repeated frames.
- Latency: a pushed word is visible on `out_data` with `out_valid`=1 in the cycle after the stop-bit sample edge.
- Error pulses are registered and fire in the cycle after the stop-bit sample edge.
- FIFO:
  - Registered storage; `out_data` driven combinationally from the head entry.
  - Pop occurs when `out_valid` and `out_ready` are both 1.
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot).
  - Push while full without a same-cycle pop: word dropped, `overflow` set, `err_count` incremented.
  - Pointers wrap modulo `FIFO_DEPTH`, with an extra MSB to distinguish full from empty.
  - Pop while empty is ignored.
- `err_count`:
  - +1 per parity error, frame error or overflow event; at most one event per frame.
  - Saturates at all-ones.
  - `clr_err`=1 zeroes `err_count` and `overflow`. If an error event occurs in the same cycle as `clr_err`, the clear wins and the event is lost.
- `out_data` holds its last value when the FIFO is empty; it is don't-care while `out_valid`=0.

Test Plan:
- Nominal frame: `bit_en`=1 every cycle, send 0xA5 as start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> `out_valid`=1 with `out_data`=0xA5 one cycle after the stop sample; `err_count`=0.
- Parity error: 0x3C with parity bit 1 -> one-cycle `parity_err` pulse, no push, `err_count`=1.
- Framing error and BREAK: 0x55 with stop bit 0, then `ser_in` held 0 for 20 bits, then 1 -> exactly one `frame_err` pulse, FSM stays in BREAK, no further frames; next valid frame 0x12 is received correctly.
- Overflow and simultaneous push/pop:
  - `out_ready`=0, send 5 good frames 0x01..0x05 -> FIFO holds 0x01..0x04, `overflow`=1, `err_count`=1.
  - Then raise `out_ready`=1 in the cycle a 6th frame 0x06 pushes while the FIFO is full -> pops read 0x01,0x02,0x03,0x04,0x06.
- Strobed timing: `bit_en`=1 every 4th cycle, frame 0xFF -> word delivered correctly; `busy` stays 1 from the start-bit sample through the stop-bit sample.
- Reset mid-frame: assert `rst_n`=0 after 3 data bits with 2 words queued -> `out_valid`=0, `busy`=0, `err_count`=0 immediately; after release, frame 0x80 is received correctly.

Source files
------------

// File: rtl/serdes_frame_rx.sv
// serdes_frame_rx: recovers start/data/parity/stop frames from a strobed
// serial line, checks parity and stop bit, and queues good words in a
// small FIFO drained through a valid/ready handshake.
module serdes_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_in,
    input  logic                 bit_en,
    input  logic                 clr_err,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                               state_q, state_d;
    logic [DATA_W-1:0]                    shreg_q, shreg_d;
    logic [CW-1:0]                        bcnt_q, bcnt_d;
    logic                                 perr_q, perr_d;
    logic                                 parity_err_q, parity_err_d;
    logic                                 frame_err_q, frame_err_d;
    logic                                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0]                 err_cnt_q, err_cnt_d;
    logic [AW:0]                          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0]    mem_q, mem_d;

    logic push, perr_evt, ferr_evt, ovf_evt;
    logic empty, full, pop, wr_en;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; only strobed cycles move it
    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                S_IDLE:   if (!ser_in) state_d = S_DATA;
                S_DATA:   if (bcnt_q == CW'(DATA_W-1))
                              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = ser_in ? S_IDLE : S_BREAK;
                S_BREAK:  if (ser_in) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: stop-bit decisions that drive the FIFO and error logic
    always_comb begin
        push     = 1'b0;
        perr_evt = 1'b0;
        ferr_evt = 1'b0;
        busy     = (state_q != S_IDLE);
        if (bit_en && state_q == S_STOP) begin
            push     = ser_in && !perr_q;
            perr_evt = ser_in && perr_q;
            // a bad stop bit masks any parity failure
            ferr_evt = !ser_in;
        end
    end

    // shift register, bit counter and parity result
    always_comb begin
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        perr_d  = perr_q;
        if (bit_en) begin
            case (state_q)
                S_IDLE: if (!ser_in) begin
                    bcnt_d = '0;
                    perr_d = 1'b0;
                end
                S_DATA: begin
                    // LSB arrives first, so shift in at the top
                    shreg_d = {ser_in, shreg_q[DATA_W-1:1]};
                    if (bcnt_q != CW'(DATA_W-1)) bcnt_d = bcnt_q + CW'(1);
                end
                S_PARITY: perr_d = (^shreg_q) ^ ser_in;
                default: ;
            endcase
        end
    end

    // FIFO control: a pop frees the slot for a same-cycle push when full
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop     = !empty && out_ready;
        wr_en   = push && (!full || pop);
        ovf_evt = push && full && !pop;
        mem_d   = mem_q;
        if (wr_en) mem_d[wptr_q[AW-1:0]] = shreg_q;
        wptr_d  = wr_en ? wptr_q + {{AW{1'b0}}, 1'b1} : wptr_q;
        rptr_d  = pop   ? rptr_q + {{AW{1'b0}}, 1'b1} : rptr_q;
    end

    // error pulses, sticky overflow and saturating counter; clear wins
    always_comb begin
        parity_err_d = perr_evt;
        frame_err_d  = ferr_evt;
        overflow_d   = overflow_q || ovf_evt;
        err_cnt_d    = err_cnt_q;
        if ((perr_evt || ferr_evt || ovf_evt) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        if (clr_err) begin
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    // datapath, FIFO and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q      <= '0;
            bcnt_q       <= '0;
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            mem_q        <= '0;
        end else begin
            shreg_q      <= shreg_d;
            bcnt_q       <= bcnt_d;
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            err_cnt_q    <= err_cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            mem_q        <= mem_d;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = mem_q[rptr_q[AW-1:0]];
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_serdes_frame_rx.sv
// Directed bench for serdes_frame_rx: frames are driven bit by bit, good
// words are queued as expectations and compared as the FIFO is drained.
module tb_serdes_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n, ser_in, bit_en, clr_err, out_ready;
    logic [7:0] out_data;
    logic       out_valid, parity_err, frame_err, overflow, busy;
    logic [7:0] err_count;

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt;
    logic [7:0] sb[$];

    serdes_frame_rx #(.DATA_W(8), .PARITY_EN(1), .FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .bit_en(bit_en),
        .clr_err(clr_err), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted head word must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL pop_unexpected: got %0h expected none", out_data);
            end
            if (sb.size() != 0) chk("pop_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
    end

    // one serial bit held for per cycles, strobed in the last one
    task automatic send_bit(input logic b, input int per, input bit chkb, input bit rdy);
        ser_in = b;
        for (int c = 0; c < per; c++) begin
            bit_en = (c == per - 1);
            if (rdy && c == per - 1) out_ready = 1'b1;
            if (chkb) chk("busy_in_frame", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        bit_en = 1'b0;
        if (rdy) out_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              input int per, input bit chkb, input bit rdy);
        send_bit(1'b0, per, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], per, chkb, 1'b0);
        send_bit((^d) ^ flip, per, chkb, 1'b0);
        send_bit(stop, per, chkb, rdy);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ser_in = 1'b1; bit_en = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_flags", {29'd0, overflow, parity_err, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // nominal frame
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        chk("nom_valid", {31'd0, out_valid}, 32'd1);
        chk("nom_data", {24'd0, out_data}, 32'hA5);
        chk("nom_err_count", {24'd0, err_count}, 32'd0);
        chk("nom_busy_after", {31'd0, busy}, 32'd0);
        drain(1);
        chk("nom_drained", {31'd0, out_valid}, 32'd0);

        // parity error
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        chk("par_pulse", {30'd0, parity_err, frame_err}, 32'd2);
        chk("par_no_push", {31'd0, out_valid}, 32'd0);
        chk("par_err_count", {24'd0, err_count}, 32'd1);
        @(posedge clk); #1;
        chk("par_pulse_end", {31'd0, parity_err}, 32'd0);

        // framing error, then stuck-low line held in BREAK
        send_frame(8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        chk("frm_pulse", {30'd0, parity_err, frame_err}, 32'd1);
        chk("frm_err_count", {24'd0, err_count}, 32'd2);
        fe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0, 1, 1'b1, 1'b0);
            if (frame_err) fe_cnt++;
        end
        chk("brk_no_more_ferr", fe_cnt, 32'd0);
        chk("brk_no_push", {31'd0, out_valid}, 32'd0);
        chk("brk_err_count", {24'd0, err_count}, 32'd2);
        send_bit(1'b1, 1, 1'b1, 1'b0);
        chk("brk_exit_idle", {31'd0, busy}, 32'd0);
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        chk("brk_next_data", {24'd0, out_data}, 32'h12);
        drain(1);

        // clear, then overflow with a full FIFO
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk("clr_err_count", {24'd0, err_count}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            send_frame(8'(i), 1'b0, 1'b1, 1, 1'b0, 1'b0);
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_err_count", {24'd0, err_count}, 32'd1);
        chk("ovf_head", {24'd0, out_data}, 32'h01);
        // push into a full FIFO with a same-cycle pop
        sb.push_back(8'h06);
        send_frame(8'h06, 1'b0, 1'b1, 1, 1'b0, 1'b1);
        chk("pp_err_count", {24'd0, err_count}, 32'd1);
        chk("pp_head", {24'd0, out_data}, 32'h02);
        drain(4);
        chk("pp_drained", {31'd0, out_valid}, 32'd0);
        chk("pp_sb_empty", sb.size(), 32'd0);

        // strobed timing, one bit every 4 cycles
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b0, 1'b1, 4, 1'b1, 1'b0);
        chk("strb_valid", {31'd0, out_valid}, 32'd1);
        chk("strb_data", {24'd0, out_data}, 32'hFF);
        chk("strb_busy_after", {31'd0, busy}, 32'd0);
        drain(1);

        // reset mid-frame with two words queued
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        sb.push_back(8'h22);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        send_bit(1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1, 1'b0, 1'b0);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        ser_in = 1'b1;
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_err_count", {24'd0, err_count}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back(8'h80);
        send_frame(8'h80, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        chk("rec_data", {24'd0, out_data}, 32'h80);
        drain(1);
        chk("end_sb_empty", sb.size(), 32'd0);
        chk("end_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
